uncore_region_sequencer: RTL
============================

// Module: uncore_region_sequencer
// PURPOSE
//  Sequences one uncore access at a time from the bus-side requester to the peripheral region selected by the address decoder.
//  Consumes the 14-bit one-hot region select (bit 0 = unmapped) sampled with the request and runs an APB-style SETUP/ACCESS
//  handshake to the selected peripheral. Returns read data or an access-fault response.
//  Sits between the uncore bus bridge and the per-region peripherals (DTIM..BSG DMC).
// PARAMETERS
//  PA_BITS   56   physical address width
//  XLEN      64   data width
//  NREG      14   region select width; bit 0 = no region
//  TIMEOUT   255  max ACCESS cycles waiting for PeriphReady before fault; 1..2^16-1
// PORTS
//  HCLK         in   1            clock
//  HRESETn      in   1            async active-low reset
//  ReqValid     in   1            request present
//  ReqReady     out  1            sequencer accepts request (IDLE only)
//  ReqWrite     in   1            1 = write, 0 = read
//  ReqAdr       in   PA_BITS      physical address
//  ReqSize      in   2            log2 bytes
//  ReqWData     in   XLEN         write data
//  SelRegions   in   NREG         decoder output, sampled with request
//  PeriphSel    out  NREG         one-hot peripheral select; bit 0 never driven
//  PeriphEnable out  1            ACCESS phase strobe
//  PeriphWrite  out  1            registered ReqWrite
//  PeriphAdr    out  PA_BITS      registered ReqAdr
//  PeriphSize   out  2            registered ReqSize
//  PeriphWData  out  XLEN         registered ReqWData
//  PeriphReady  in   NREG         per-region completion; only selected bit observed
//  PeriphRData  in   NREG*XLEN    per-region read data, region i at [i*XLEN +: XLEN]
//  PeriphAbort  out  1            one-cycle pulse on timeout
//  RspValid     out  1            response available
//  RspReady     in   1            requester takes response
//  RspErr       out  1            access fault (unmapped, multi-hit, timeout)
//  RspRData     out  XLEN         read data; 0 on writes and errors
// BEHAVIOUR
//  Reset (async, HRESETn=0): state IDLE; all outputs 0 except ReqReady=1; counter 0. Mid-transaction reset drops the
//   transaction silently; no response, no abort pulse.
//  States: IDLE, SETUP, ACCESS, RESP.
//  IDLE: ReqReady=1. ReqValid=1 registers Req*/SelRegions. Go to RESP with RspErr=1 if SelRegions[0]=1, SelRegions=0, or
//   more than one bit set; no PeriphSel asserted. Otherwise go to SETUP.
//  SETUP (exactly 1 cycle): PeriphSel=registered one-hot, PeriphEnable=0 -> ACCESS.
//  ACCESS: PeriphSel held, PeriphEnable=1. Counter increments each cycle from 0.
//   - PeriphReady[sel]=1: capture PeriphRData slice (reads), RspErr=0 -> RESP. Ready in first ACCESS cycle is legal (min latency).
//   - Counter reaches TIMEOUT-1 with no ready: PeriphAbort=1 that cycle, RspErr=1 -> RESP.
//   - Ready and timeout in same cycle: ready wins, no abort.
//  RESP: PeriphSel=0, PeriphEnable=0. RspValid=1, RspErr/RspRData stable until RspReady=1. Then -> IDLE, RspValid drops next cycle.
//  Latency, mapped, Ready in 1st ACCESS: request accepted cycle 0; SETUP 1; ACCESS 2; RspValid cycle 3.
//  Latency, unmapped: RspValid on the cycle after acceptance.
//  Back-to-back: new request is accepted only in IDLE, earliest the cycle after the RspReady handshake.
//  PeriphAdr/Write/Size/WData: hold last accepted request; change only on acceptance.
//  Counter: clog2(TIMEOUT+1) bits, cleared on SETUP entry; never wraps.
//  PeriphReady bits of unselected regions and PeriphRData of unselected regions are ignored.
// TESTING
//  Read CLINT (SelRegions=14'h0040), PeriphReady[6] on 2nd ACCESS cycle, RData=64'hDEAD_BEEF -> RspValid cycle 4, RspErr=0, RspRData=64'hDEAD_BEEF.
//  SelRegions=14'h0001 (unmapped) read -> no PeriphSel, RspValid next cycle, RspErr=1, RspRData=0.
//  SelRegions=14'h0180 (GPIO+UART multi-hit) -> no PeriphSel, RspErr=1.
//  TIMEOUT=4, UART selected, PeriphReady never asserted -> PeriphAbort 1-cycle pulse on 4th ACCESS cycle, then RspErr=1.
//  Write to PLIC with RspReady held 0 for 5 cycles -> RspValid/RspErr held stable, ReqReady=0 throughout; IDLE after handshake.
//  HRESETn low during ACCESS -> PeriphSel/PeriphEnable/RspValid 0 immediately, ReqReady=1 after release; next read completes normally.

Source files
------------

// File: rtl/uncore_region_sequencer.sv
// -----------------------------------------------------------------------------
// uncore_region_sequencer
//
// Purpose:
//   Runs one uncore access at a time from the bus-side requester to the
//   peripheral region chosen by the address decoder. The one-hot region
//   select is registered together with the request. A mapped request then
//   runs an APB-style SETUP/ACCESS handshake with that region. An unmapped
//   request, an empty select or a multi-hit select goes straight to an
//   access-fault response. An ACCESS phase that waits too long for the
//   region's ready is aborted and also answered with a fault.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   ReqValid/ReqReady      request handshake (ReqReady only in IDLE)
//   ReqWrite/Adr/Size/WData request attributes, registered on acceptance
//   SelRegions             decoder one-hot region select (bit 0 = unmapped)
//   PeriphSel/Enable       APB-style select and ACCESS strobe to regions
//   PeriphWrite/Adr/Size/WData  attributes of the last accepted request
//   PeriphReady/RData      per-region completion and read data
//   PeriphAbort            one-cycle pulse when an ACCESS phase times out
//   RspValid/RspReady      response handshake
//   RspErr/RspRData        fault flag and read data (0 on writes/faults)
// -----------------------------------------------------------------------------
module uncore_region_sequencer #(
   parameter int PA_BITS = 56,
   parameter int XLEN    = 64,
   parameter int NREG    = 14,
   parameter int TIMEOUT = 255
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic                   ReqValid,
   output logic                   ReqReady,
   input  logic                   ReqWrite,
   input  logic [PA_BITS-1:0]     ReqAdr,
   input  logic [1:0]             ReqSize,
   input  logic [XLEN-1:0]        ReqWData,
   input  logic [NREG-1:0]        SelRegions,
   output logic [NREG-1:0]        PeriphSel,
   output logic                   PeriphEnable,
   output logic                   PeriphWrite,
   output logic [PA_BITS-1:0]     PeriphAdr,
   output logic [1:0]             PeriphSize,
   output logic [XLEN-1:0]        PeriphWData,
   input  logic [NREG-1:0]        PeriphReady,
   input  logic [NREG*XLEN-1:0]   PeriphRData,
   output logic                   PeriphAbort,
   output logic                   RspValid,
   input  logic                   RspReady,
   output logic                   RspErr,
   output logic [XLEN-1:0]        RspRData
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic                 write_q, write_d;
   logic [PA_BITS-1:0]   adr_q,   adr_d;
   logic [1:0]           size_q,  size_d;
   logic [XLEN-1:0]      wdata_q, wdata_d;
   logic [NREG-1:0]      sel_q,   sel_d;
   logic [CNT_W-1:0]     cnt_q,   cnt_d;
   logic                 err_q,   err_d;
   logic [XLEN-1:0]      rdata_q, rdata_d;

   logic                 req_sel_ok;
   logic                 sel_ready;
   logic [XLEN-1:0]      sel_rdata;
   logic                 timeout_hit;
   logic                 abort_pulse;

   // A select is usable only if exactly one bit is set and that bit is not
   // the "unmapped" bit 0. x & (x-1) clears the lowest set bit, so a zero
   // result means at most one bit was set.
   always_comb begin
      req_sel_ok = (SelRegions != '0) && !SelRegions[0] &&
                   ((SelRegions & (SelRegions - NREG'(1))) == '0);
   end

   // Only the selected region's ready and data are observed. Because sel_q
   // is one-hot whenever ACCESS is reached, OR-ing the gated slices is a
   // plain one-hot mux.
   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NREG; i++) begin
         if (sel_q[i]) begin
            sel_rdata = sel_rdata | PeriphRData[i*XLEN +: XLEN];
         end
      end
   end

   assign sel_ready   = |(PeriphReady & sel_q);
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Next-state and datapath capture
   always_comb begin
      // NOTE: every variable gets a default before the case statement, so no
      // path through the block leaves a value unassigned and no latch is
      // inferred.
      state_d     = state_q;
      write_d     = write_q;
      adr_d       = adr_q;
      size_d      = size_q;
      wdata_d     = wdata_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      abort_pulse = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (ReqValid) begin
               write_d = ReqWrite;
               adr_d   = ReqAdr;
               size_d  = ReqSize;
               wdata_d = ReqWData;
               sel_d   = SelRegions;
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = !req_sel_ok;
               state_d = req_sel_ok ? ST_SETUP : ST_RESP;
            end
         end

         ST_SETUP: begin
            state_d = ST_ACCESS;
         end

         ST_ACCESS: begin
            // Ready is tested first so that it wins over a simultaneous
            // timeout.
            if (sel_ready) begin
               rdata_d = write_q ? '0 : sel_rdata;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               abort_pulse = 1'b1;
               rdata_d     = '0;
               err_d       = 1'b1;
               state_d     = ST_RESP;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RESP: begin
            if (RspReady) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         // NOTE: the request and response holding registers are reset along
         // with the state, so every Periph*/Rsp* output reads 0 straight out
         // of reset instead of showing stale or X data.
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         adr_q   <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments let every register sample the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         write_q <= write_d;
         adr_q   <= adr_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decoded from the current state
   always_comb begin
      ReqReady     = 1'b0;
      PeriphSel    = '0;
      PeriphEnable = 1'b0;
      RspValid     = 1'b0;
      RspErr       = 1'b0;
      RspRData     = '0;

      unique case (state_q)
         ST_IDLE: begin
            ReqReady = 1'b1;
         end
         ST_SETUP: begin
            // Bit 0 means "no region" and is never driven to a peripheral.
            PeriphSel = {sel_q[NREG-1:1], 1'b0};
         end
         ST_ACCESS: begin
            PeriphSel    = {sel_q[NREG-1:1], 1'b0};
            PeriphEnable = 1'b1;
         end
         ST_RESP: begin
            RspValid = 1'b1;
            RspErr   = err_q;
            RspRData = rdata_q;
         end
         default: begin
            ReqReady = 1'b0;
         end
      endcase
   end

   assign PeriphAbort = abort_pulse;
   assign PeriphWrite = write_q;
   assign PeriphAdr   = adr_q;
   assign PeriphSize  = size_q;
   assign PeriphWData = wdata_q;

endmodule
